// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC,
// PRId and Config. Written by mtc0 from MEM/WB, read by mfc0 in EX.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_RESET = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic        timer_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic        wp_q;
  logic        iv_q;

  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic timer_match;

  assign wr_count    = we_i && (waddr_i == REG_COUNT);
  assign wr_compare  = we_i && (waddr_i == REG_COMPARE);
  assign wr_status   = we_i && (waddr_i == REG_STATUS);
  assign wr_cause    = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc      = we_i && (waddr_i == REG_EPC);
  // Compare of zero disables the timer.
  assign timer_match = (compare_q != 32'h0) && (count_q == compare_q);

  // Free-running Count; an mtc0 to Count replaces this cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= 32'h0;
    else if (wr_count)
      count_q <= wdata_i;
    else
      count_q <= count_q + 32'h1;
  end

  // Compare register and sticky timer interrupt; a Compare write acks it
  // and wins over a match seen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= 32'h0;
      timer_q   <= 1'b0;
    end else if (wr_compare) begin
      compare_q <= wdata_i;
      timer_q   <= 1'b0;
    end else if (timer_match) begin
      timer_q   <= 1'b1;
    end
  end

  // Status and EPC are plain full-width registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      epc_q    <= 32'h0;
    end else begin
      if (wr_status) status_q <= wdata_i;
      if (wr_epc)    epc_q    <= wdata_i;
    end
  end

  // Cause: hardware IP bits track int_i every cycle; only IP[9:8], WP and
  // IV are software-writable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_hw_q <= 6'h0;
      ip_sw_q <= 2'h0;
      wp_q    <= 1'b0;
      iv_q    <= 1'b0;
    end else begin
      ip_hw_q <= int_i;
      if (wr_cause) begin
        ip_sw_q <= wdata_i[9:8];
        wp_q    <= wdata_i[22];
        iv_q    <= wdata_i[23];
      end
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = {8'h00, iv_q, wp_q, 6'h00, ip_hw_q, ip_sw_q, 8'h00};
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_RESET;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_q;

  // mfc0 read mux; no bypass of an in-flight write.
  always_comb begin
    data_o = 32'h0;
    case (raddr_i)
      REG_COUNT:   data_o = count_o;
      REG_COMPARE: data_o = compare_o;
      REG_STATUS:  data_o = status_o;
      REG_CAUSE:   data_o = cause_o;
      REG_EPC:     data_o = epc_o;
      REG_PRID:    data_o = prid_o;
      REG_CONFIG:  data_o = config_o;
      default:     data_o = 32'h0;
    endcase
  end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file; consumer at the far end of the MEM/WB write-back interface for mtc0 writes.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Runs the Count/Compare timer, samples external interrupt lines into Cause, and serves one combinational read port to the EX stage for mfc0.

Parameters:
- PRID_VALUE, 32'h004C0102, constant returned for PRId (reg 15).
- CONFIG_RESET, 32'h00008000, reset and constant value of Config (reg 16); BE=1.
- STATUS_RESET, 32'h10000000, reset value of Status (reg 12); CU0=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- we_i  in  1  write enable, driven by wb_cp0_we.
- waddr_i  in  5  CP0 register number to write, driven by wb_cp0_waddr.
- wdata_i  in  32  write data, driven by wb_cp0_wdata.
- raddr_i  in  5  CP0 register number to read (EX stage, mfc0).
- int_i  in  6  external hardware interrupt lines.
- data_o  out  32  read data for raddr_i, combinational.
- count_o  out  32  Count (reg 9).
- compare_o  out  32  Compare (reg 11).
- status_o  out  32  Status (reg 12).
- cause_o  out  32  Cause (reg 13).
- epc_o  out  32  EPC (reg 14).
- config_o  out  32  Config (reg 16).
- prid_o  out  32  PRId (reg 15).
- timer_int_o  out  1  timer interrupt request, registered.

Behaviour:
- Reset (async, rst=1):
  - count_o, compare_o, cause_o, epc_o = 0; timer_int_o = 0.
  - status_o = STATUS_RESET; config_o = CONFIG_RESET; prid_o = PRID_VALUE.
  - Outputs hold these values while rst=1. The first increment happens at the first rising edge after rst drops.
- Count:
  - Increments by 1 every cycle, modulo 2^32 (0xFFFFFFFF -> 0x00000000, no flag).
  - A write to reg 9 loads wdata_i at the next edge, replacing that cycle's increment. Counting resumes from the written value.
- Timer:
  - Each edge, if compare_o != 0 and count_o == compare_o, timer_int_o <= 1.
  - timer_int_o stays 1 until a write to reg 11.
  - A reg 11 write loads compare_o and forces timer_int_o <= 0 at the same edge. This has priority over a match in that same cycle.
  - compare_o == 0 never raises timer_int_o.
- Cause:
  - cause_o[15:10] <= int_i every cycle, unconditionally. Software writes to these bits are ignored.
  - A reg 13 write updates only IP[9:8], WP[22] and IV[23] from wdata_i.
  - All other Cause bits read 0.
- Status and EPC: a write to reg 12 or reg 14 loads all 32 bits.
- Read-only and unmapped:
  - Writes to reg 15 or 16, or to any unmapped address, have no effect.
  - Reads of unmapped addresses return 0.
- Write latency: written value is visible on the outputs and data_o one cycle after we_i is sampled high. No internal bypass from write to read; forwarding of in-flight mtc0 is done by the pipeline.
- Read port: data_o is a pure combinational mux of raddr_i over the current register values. It is independent of we_i.
- Simultaneous read and write of the same register: data_o shows the old value until the edge.
- Reset mid-operation: all state is immediately forced to reset values, including a pending timer_int_o.

Test Plan:
- Reset, then idle 5 cycles:
  - count_o = 5, status_o = 0x10000000, config_o = 0x00008000, prid_o = 0x004C0102.
  - raddr_i = 16 gives data_o = 0x00008000; raddr_i = 7 gives data_o = 0.
- Write Compare = 0x20, then write Count = 0x1E:
  - timer_int_o rises 3 edges after the Count write (count 0x1E -> 0x1F -> 0x20, set on the match edge) and stays high.
  - A later Compare write of 0x100 clears it the next cycle.
- Write Count = 0xFFFFFFFE:
  - Next cycles count_o = 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
  - timer_int_o stays 0 with compare_o = 0.
- int_i = 6'b101001, then write Cause = 0xFFFFFFFF:
  - cause_o = 0x00C0A700 (bits 23, 22, 15, 13, 10, 9, 8 set).
  - Change int_i to 0: cause_o = 0x00C00300 the next cycle.
- Write PRId = 0x1234, Config = 0, addr 20 = 0xDEAD: no register changes.
- Write EPC = 0xBFC00100 and assert rst asynchronously mid-cycle: epc_o returns to 0 before the next clock edge.
